// File: rtl/wallace_mul_sequencer_if.sv
// Handshake and multiplier-side bundle for wallace_mul_sequencer: an operand
// channel, a result channel and the nibble port of the shared 4x4 multiplier.
interface wallace_mul_sequencer_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [3:0]     mul_a;
    logic [3:0]     mul_b;
    logic [7:0]     mul_p;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_p, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_p, busy
    );
endinterface

// File: rtl/wallace_mul_sequencer.sv
// W x W unsigned multiplier built by sequencing nibble products through one external 4x4 multiplier.
// Optional build macro MUL_REG_EN registers mul_p before accumulation (one extra drain cycle).
module wallace_mul_sequencer #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wallace_mul_sequencer_if.slave bus
);
    localparam int N  = W / 4;
    localparam int NN = N * N;
    localparam int KW = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] I_LAST = 4'(N - 1);
`ifdef MUL_REG_EN
    localparam logic [KW-1:0] K_LAST = KW'(NN);
`else
    localparam logic [KW-1:0] K_LAST = KW'(NN - 1);
`endif

    logic [1:0]     state_r;
    logic [KW-1:0]  k_r;
    logic [3:0]     i_r;
    logic [3:0]     j_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [2*W-1:0] acc_r;
    logic [3:0]     mul_a_r;
    logic [3:0]     mul_b_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [2*W-1:0] out_p_r;
    logic           busy_r;
`ifdef MUL_REG_EN
    logic [7:0]     prod_r;
    logic [7:0]     psh_r;
`endif

    logic [3:0]     i_nx_s;
    logic [3:0]     j_nx_s;
    logic [7:0]     sh_s;
    logic           last_s;
    logic           issue_nx_s;
    logic [7:0]     add_s;
    logic [7:0]     add_sh_s;
    logic           add_en_s;
    logic [2*W-1:0] acc_nx_s;

    function automatic logic [3:0] nib(input logic [W-1:0] x, input logic [3:0] idx);
        logic [3:0] r;
        r = 4'd0;
        for (int n = 0; n < N; n++) begin
            if (idx == 4'(n)) r = x[4*n +: 4];
        end
        return r;
    endfunction

    // Step bookkeeping: next nibble indices, partial-product shift and accumulator update.
    always_comb begin
        i_nx_s = (i_r == I_LAST) ? 4'd0 : i_r + 4'd1;
        j_nx_s = (i_r == I_LAST) ? j_r + 4'd1 : j_r;
        sh_s   = ({4'd0, i_r} + {4'd0, j_r}) << 2'd2;
        last_s = (k_r == K_LAST);
`ifdef MUL_REG_EN
        // Accumulate the product issued one cycle earlier; k=0 has nothing captured yet.
        add_s      = prod_r;
        add_sh_s   = psh_r;
        add_en_s   = (k_r != {KW{1'b0}});
        issue_nx_s = (k_r < KW'(NN - 1));
`else
        add_s      = bus.mul_p;
        add_sh_s   = sh_s;
        add_en_s   = 1'b1;
        issue_nx_s = !last_s;
`endif
        if (add_en_s) begin
            acc_nx_s = acc_r + ({{(2*W-8){1'b0}}, add_s} << add_sh_s);
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Control FSM, operand capture, multiplier issue and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            k_r         <= {KW{1'b0}};
            i_r         <= 4'd0;
            j_r         <= 4'd0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            acc_r       <= {(2*W){1'b0}};
            mul_a_r     <= 4'd0;
            mul_b_r     <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_p_r     <= {(2*W){1'b0}};
            busy_r      <= 1'b0;
`ifdef MUL_REG_EN
            prod_r      <= 8'd0;
            psh_r       <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state_r    <= ST_RUN;
                        a_r        <= bus.in_a;
                        b_r        <= bus.in_b;
                        acc_r      <= {(2*W){1'b0}};
                        k_r        <= {KW{1'b0}};
                        i_r        <= 4'd0;
                        j_r        <= 4'd0;
                        mul_a_r    <= bus.in_a[3:0];
                        mul_b_r    <= bus.in_b[3:0];
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nx_s;
`ifdef MUL_REG_EN
                    prod_r <= bus.mul_p;
                    psh_r  <= sh_s;
`endif
                    if (last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_p_r     <= acc_nx_s;
                        mul_a_r     <= 4'd0;
                        mul_b_r     <= 4'd0;
                    end else begin
                        k_r     <= k_r + KW'(1);
                        i_r     <= i_nx_s;
                        j_r     <= j_nx_s;
                        mul_a_r <= issue_nx_s ? nib(a_r, i_nx_s) : 4'd0;
                        mul_b_r <= issue_nx_s ? nib(b_r, j_nx_s) : 4'd0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    mul_a_r     <= 4'd0;
                    mul_b_r     <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = out_p_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_wallace_mul_sequencer.sv
// Directed bench for wallace_mul_sequencer: W=8 and W=16 instances sharing clock and reset,
// each driven through its interface with a behavioural 4x4 multiplier on mul_p.
module tb_wallace_mul_sequencer;
`ifdef MUL_REG_EN
    localparam int LAT8  = 5;
    localparam int LAT16 = 17;
`else
    localparam int LAT8  = 4;
    localparam int LAT16 = 16;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wallace_mul_sequencer_if #(.W(8))  v8 ();
    wallace_mul_sequencer_if #(.W(16)) v16 ();

    wallace_mul_sequencer #(.W(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(v8.slave));
    wallace_mul_sequencer #(.W(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(v16.slave));

    assign v8.mul_p  = {4'd0, v8.mul_a} * {4'd0, v8.mul_b};
    assign v16.mul_p = {4'd0, v16.mul_a} * {4'd0, v16.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=8 product: nibble issue order, fixed latency, result, optional handshake.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit take);
        check("w8_ready_before", 64'(v8.in_ready), 64'(1'b1));
        v8.in_a = a;
        v8.in_b = b;
        v8.in_valid = 1'b1;
        tick();
        v8.in_valid = 1'b0;
        for (int c = 0; c < LAT8; c++) begin
            if (c < 4) begin
                check("w8_mul_a", 64'(v8.mul_a), 64'(a[(c % 2) * 4 +: 4]));
                check("w8_mul_b", 64'(v8.mul_b), 64'(b[(c / 2) * 4 +: 4]));
            end
            check("w8_valid_early", 64'(v8.out_valid), 64'(1'b0));
            check("w8_busy_run", 64'(v8.busy), 64'(1'b1));
            check("w8_ready_run", 64'(v8.in_ready), 64'(1'b0));
            tick();
        end
        check("w8_valid_on_time", 64'(v8.out_valid), 64'(1'b1));
        check("w8_out_p", 64'(v8.out_p), 64'(exp));
        check("w8_mul_a_idle", 64'(v8.mul_a), 64'(4'd0));
        if (take) begin
            v8.out_ready = 1'b1;
            tick();
            v8.out_ready = 1'b0;
            check("w8_valid_after_take", 64'(v8.out_valid), 64'(1'b0));
            check("w8_ready_after_take", 64'(v8.in_ready), 64'(1'b1));
            check("w8_out_p_kept", 64'(v8.out_p), 64'(exp));
        end
    endtask

    // One W=16 product with latency and result checks, always consumed.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        check("w16_ready_before", 64'(v16.in_ready), 64'(1'b1));
        v16.in_a = a;
        v16.in_b = b;
        v16.in_valid = 1'b1;
        tick();
        v16.in_valid = 1'b0;
        for (int c = 0; c < LAT16; c++) begin
            check("w16_valid_early", 64'(v16.out_valid), 64'(1'b0));
            tick();
        end
        check("w16_valid_on_time", 64'(v16.out_valid), 64'(1'b1));
        check("w16_out_p", 64'(v16.out_p), 64'(exp));
        v16.out_ready = 1'b1;
        tick();
        v16.out_ready = 1'b0;
        check("w16_valid_after_take", 64'(v16.out_valid), 64'(1'b0));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        v8.in_valid = 1'b0;  v8.in_a = 8'd0;   v8.in_b = 8'd0;   v8.out_ready = 1'b0;
        v16.in_valid = 1'b0; v16.in_a = 16'd0; v16.in_b = 16'd0; v16.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(v8.in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(v8.out_valid), 64'(1'b0));
        check("rst_out_p", 64'(v8.out_p), 64'(16'h0000));
        check("rst_busy", 64'(v8.busy), 64'(1'b0));
        check("rst_mul_a", 64'(v8.mul_a), 64'(4'd0));
        check("rst_mul_b", 64'(v8.mul_b), 64'(4'd0));
        check("rst_w16_ready", 64'(v16.in_ready), 64'(1'b1));
        rst_n = 1'b1;
        tick();

        op8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        op8(8'h12, 8'h34, 16'h03A8, 1'b1);
        op8(8'h00, 8'hA5, 16'h0000, 1'b1);

        // Result held for 10 cycles while new operands are offered.
        op8(8'h2A, 8'h03, 16'h007E, 1'b0);
        for (int c = 0; c < 10; c++) begin
            v8.in_valid = 1'b1;
            v8.in_a = 8'h0F;
            v8.in_b = 8'hF0;
            tick();
            check("hold_valid", 64'(v8.out_valid), 64'(1'b1));
            check("hold_out_p", 64'(v8.out_p), 64'(16'h007E));
            check("hold_in_ready", 64'(v8.in_ready), 64'(1'b0));
        end
        v8.in_valid = 1'b0;
        v8.out_ready = 1'b1;
        tick();
        v8.out_ready = 1'b0;
        check("hold_release_valid", 64'(v8.out_valid), 64'(1'b0));
        check("hold_release_busy", 64'(v8.busy), 64'(1'b0));
        op8(8'h05, 8'h06, 16'h001E, 1'b1);

        // Operands offered during RUN must not disturb the product in flight.
        v8.in_a = 8'h33;
        v8.in_b = 8'h44;
        v8.in_valid = 1'b1;
        tick();
        v8.in_a = 8'h0F;
        v8.in_b = 8'hF0;
        tick();
        check("run_ign_mul_a", 64'(v8.mul_a), 64'(4'h3));
        for (int c = 1; c < LAT8; c++) tick();
        check("run_ign_valid", 64'(v8.out_valid), 64'(1'b1));
        check("run_ign_out_p", 64'(v8.out_p), 64'(16'h0D8C));
        v8.in_valid = 1'b0;
        v8.out_ready = 1'b1;
        tick();
        v8.out_ready = 1'b0;

        // Asynchronous reset at step 2 aborts the product.
        v8.in_a = 8'h12;
        v8.in_b = 8'h34;
        v8.in_valid = 1'b1;
        tick();
        v8.in_valid = 1'b0;
        tick();
        tick();
        check("step2_mul_a", 64'(v8.mul_a), 64'(4'h2));
        check("step2_mul_b", 64'(v8.mul_b), 64'(4'h3));
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(v8.out_valid), 64'(1'b0));
        check("abort_out_p", 64'(v8.out_p), 64'(16'h0000));
        check("abort_in_ready", 64'(v8.in_ready), 64'(1'b1));
        check("abort_busy", 64'(v8.busy), 64'(1'b0));
        check("abort_mul_a", 64'(v8.mul_a), 64'(4'd0));
        tick();
        rst_n = 1'b1;
        tick();
        op8(8'h03, 8'h05, 16'h000F, 1'b1);

        op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op16(ra, rb, {16'd0, ra} * {16'd0, rb});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
